vram_block: RTL and testbench

Parametrised successor to the GPU's simple dual-port RAM, used for tile, palette and framebuffer storage. Adds configurable data width with per-byte write enables, selectable read-during-write behaviour, an optional output pipeline register with a read-valid flag, and a built-in sequencer that fills the whole array with a constant. One write port and one read port share a single clock. The GPU fetch logic reads; the CPU bus bridge writes.

---
 rtl/gpu_mem_pkg.sv | 17 +
 rtl/vram_clear_seq.sv | 70 +++++++
 rtl/vram_block.sv | 172 +++++++++++++++++
 tb/tb_vram_block.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_mem_pkg.sv
// -----------------------------------------------------------------------------
// gpu_mem_pkg
// Shared definitions for the GPU memory blocks.
//   READ_FIRST / WRITE_FIRST : read-during-write behaviour selectors
//   clear_state_t            : state encoding of the clear sequencer
// -----------------------------------------------------------------------------
package gpu_mem_pkg;

    localparam int READ_FIRST  = 0;
    localparam int WRITE_FIRST = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clear_state_t;

endpackage : gpu_mem_pkg

// File: rtl/vram_clear_seq.sv
// -----------------------------------------------------------------------------
// vram_clear_seq
// Sequencer that walks every word address once, requesting an all-lanes write
// of the clear value per cycle.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   clear_start    : single-cycle request, ignored while already clearing
//   busy           : high while the sequencer is in CLEAR
//   clear_we       : write request for the current clear address
//   clear_addr     : address being cleared this cycle
//   state_dbg      : current FSM state
// -----------------------------------------------------------------------------
module vram_clear_seq
    import gpu_mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_start,
    output logic                     busy,
    output logic                     clear_we,
    output logic [ADDRESS_WIDTH-1:0] clear_addr,
    output clear_state_t             state_dbg
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;

    clear_state_t             state;
    clear_state_t             state_next;
    logic [ADDRESS_WIDTH-1:0] count;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clear_start) state_next = CLEAR;
            CLEAR:   if (count == LAST_ADDR) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Address counter: held at zero while idle so entering CLEAR starts at
    // address 0; it wraps back to zero on the last address by itself.
    always_ff @(posedge clk) begin
        if (reset || state == IDLE) begin
            count <= '0;
        end else begin
            count <= count + ADDRESS_WIDTH'(1);
        end
    end

    // Outputs
    always_comb begin
        busy       = (state == CLEAR);
        clear_we   = (state == CLEAR);
        clear_addr = count;
        state_dbg  = state;
    end

endmodule : vram_clear_seq

// File: rtl/vram_block.sv
// -----------------------------------------------------------------------------
// vram_block
// Simple dual-port RAM (one write port, one read port, one clock) with
// per-byte write enables, selectable read-during-write behaviour, optional
// output register and a fill-with-constant clear sequencer.
// Ports:
//   clk, reset            : clock, synchronous active-high reset (array untouched)
//   read_addr/read_enable : read request; result appears on read_data with a
//                           one-cycle read_valid pulse after 1 (OUTPUT_REG=0)
//                           or 2 (OUTPUT_REG=1) cycles
//   write_addr/write_enable/write_byte_en/write_data : byte-masked write
//   clear_start           : pulse to fill the array with CLEAR_VALUE
//   busy                  : clear in progress, external writes dropped
//   state_dbg             : clear sequencer state
// Handshake: there is no back-pressure. read_enable is a request taken every
// cycle it is high; read_valid is a pure one-cycle qualifier of read_data, and
// read_data holds its last value while read_valid is low.
// -----------------------------------------------------------------------------
module vram_block
    import gpu_mem_pkg::*;
#(
    parameter string                 INIT_FILE     = "",
    parameter int                    ADDRESS_WIDTH = 10,
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    READ_MODE     = READ_FIRST,
    parameter int                    OUTPUT_REG    = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDRESS_WIDTH-1:0]   read_addr,
    input  logic                       read_enable,
    output logic [DATA_WIDTH-1:0]      read_data,
    output logic                       read_valid,
    input  logic [ADDRESS_WIDTH-1:0]   write_addr,
    input  logic                       write_enable,
    input  logic [DATA_WIDTH/8-1:0]    write_byte_en,
    input  logic [DATA_WIDTH-1:0]      write_data,
    input  logic                       clear_start,
    output logic                       busy,
    output clear_state_t               state_dbg
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDRESS_WIDTH;

    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("vram_block: DATA_WIDTH must be a multiple of 8");
    end

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    logic                     clear_we;
    logic [ADDRESS_WIDTH-1:0] clear_addr;

    vram_clear_seq #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_clear_seq (
        .clk         (clk),
        .reset       (reset),
        .clear_start (clear_start),
        .busy        (busy),
        .clear_we    (clear_we),
        .clear_addr  (clear_addr),
        .state_dbg   (state_dbg)
    );

    // ------------------------------------------------------------------
    // Write port mux: the clear sequencer owns the port while running,
    // external writes are simply dropped. Reset suppresses all writes.
    // ------------------------------------------------------------------
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic [LANES-1:0]         mem_be;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = write_addr;
        mem_wdata = write_data;
        mem_be    = write_byte_en;
        if (clear_we) begin
            mem_we    = 1'b1;
            mem_waddr = clear_addr;
            mem_wdata = CLEAR_VALUE;
            mem_be    = '1;
        end else if (write_enable) begin
            mem_we = 1'b1;
        end
        if (reset) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (mem_be[i]) begin
                    mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read word selection. In write-first mode a same-address write is
    // forwarded lane by lane so disabled lanes still return stored data.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged_word;
    logic [DATA_WIDTH-1:0] rd_word;

    always_comb begin
        old_word    = mem[read_addr];
        merged_word = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (mem_be[i]) begin
                merged_word[8*i +: 8] = mem_wdata[8*i +: 8];
            end
        end
        rd_word = old_word;
        if (READ_MODE == WRITE_FIRST && mem_we && mem_waddr == read_addr) begin
            rd_word = merged_word;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline. Data registers only load on a completing read so the
    // output holds between reads.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= read_enable;
            if (read_enable) begin
                s1_data <= rd_word;
            end
        end
    end

    if (OUTPUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] s2_data;
        logic                  s2_valid;

        always_ff @(posedge clk) begin
            if (reset) begin
                s2_data  <= '0;
                s2_valid <= 1'b0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign read_data  = s2_data;
        assign read_valid = s2_valid;
    end else begin : g_no_out_reg
        assign read_data  = s1_data;
        assign read_valid = s1_valid;
    end

endmodule : vram_block

// File: tb/tb_vram_block.sv
// -----------------------------------------------------------------------------
// tb_vram_block
// Directed bench for vram_block. Three instances share clock and reset:
//   dut_a : 16 x 8,  read-first,  no output register, clear value 0xEE
//   dut_b : 16 x 8,  write-first, output register,    clear value 0xEE
//   dut_w : 16 x 16, read-first,  no output register (byte-lane tests)
// dut_a and dut_b receive identical stimulus so their contents stay equal.
// -----------------------------------------------------------------------------
module tb_vram_block;
    import gpu_mem_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // shared 8-bit port stimulus (dut_a, dut_b) and shared read port
    logic [3:0]   read_addr;
    logic         read_enable;
    logic [3:0]   write_addr;
    logic         write_enable;
    logic [0:0]   write_byte_en;
    logic [7:0]   write_data;
    logic         clear_start;

    logic [7:0]   a_rdata, b_rdata;
    logic         a_valid, b_valid, a_busy, b_busy;
    clear_state_t a_state, b_state;

    // 16-bit instance
    logic [3:0]   w_waddr;
    logic         w_we;
    logic [1:0]   w_be;
    logic [15:0]  w_wdata;
    logic         w_clear;
    logic [15:0]  w_rdata;
    logic         w_valid, w_busy;
    clear_state_t w_state;

    vram_block #(
        .ADDRESS_WIDTH (4), .DATA_WIDTH (8), .READ_MODE (READ_FIRST),
        .OUTPUT_REG (0), .CLEAR_VALUE (8'hEE)
    ) dut_a (
        .clk (clk), .reset (reset),
        .read_addr (read_addr), .read_enable (read_enable),
        .read_data (a_rdata), .read_valid (a_valid),
        .write_addr (write_addr), .write_enable (write_enable),
        .write_byte_en (write_byte_en), .write_data (write_data),
        .clear_start (clear_start), .busy (a_busy), .state_dbg (a_state)
    );

    vram_block #(
        .ADDRESS_WIDTH (4), .DATA_WIDTH (8), .READ_MODE (WRITE_FIRST),
        .OUTPUT_REG (1), .CLEAR_VALUE (8'hEE)
    ) dut_b (
        .clk (clk), .reset (reset),
        .read_addr (read_addr), .read_enable (read_enable),
        .read_data (b_rdata), .read_valid (b_valid),
        .write_addr (write_addr), .write_enable (write_enable),
        .write_byte_en (write_byte_en), .write_data (write_data),
        .clear_start (clear_start), .busy (b_busy), .state_dbg (b_state)
    );

    vram_block #(
        .ADDRESS_WIDTH (4), .DATA_WIDTH (16), .READ_MODE (READ_FIRST),
        .OUTPUT_REG (0), .CLEAR_VALUE (16'h0000)
    ) dut_w (
        .clk (clk), .reset (reset),
        .read_addr (read_addr), .read_enable (read_enable),
        .read_data (w_rdata), .read_valid (w_valid),
        .write_addr (w_waddr), .write_enable (w_we),
        .write_byte_en (w_be), .write_data (w_wdata),
        .clear_start (w_clear), .busy (w_busy), .state_dbg (w_state)
    );

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_qa[$];
    logic [7:0] exp_qb[$];
    logic [7:0] model8 [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write8(input logic [3:0] addr, input logic [7:0] data);
        write_enable  = 1'b1;
        write_addr    = addr;
        write_data    = data;
        write_byte_en = 1'b1;
        tick();
        write_enable  = 1'b0;
        model8[addr]  = data;
    endtask

    task automatic write16(input logic [3:0] addr, input logic [15:0] data, input logic [1:0] be);
        w_we    = 1'b1;
        w_waddr = addr;
        w_wdata = data;
        w_be    = be;
        tick();
        w_we    = 1'b0;
    endtask

    task automatic collect(input string tag);
        if (a_valid) begin
            if (exp_qa.size() == 0) check({tag, "_extra_a"}, 32'(a_valid), 32'd0);
            else                    check({tag, "_a"}, 32'(a_rdata), 32'(exp_qa.pop_front()));
        end
        if (b_valid) begin
            if (exp_qb.size() == 0) check({tag, "_extra_b"}, 32'(b_valid), 32'd0);
            else                    check({tag, "_b"}, 32'(b_rdata), 32'(exp_qb.pop_front()));
        end
    endtask

    // Back-to-back reads of addresses lo..hi on dut_a and dut_b against model8.
    task automatic read_range(input int lo, input int hi, input string tag);
        int guard;
        for (int a = lo; a <= hi; a++) begin
            read_enable = 1'b1;
            read_addr   = 4'(a);
            exp_qa.push_back(model8[a]);
            exp_qb.push_back(model8[a]);
            tick();
            collect(tag);
        end
        read_enable = 1'b0;
        guard = 0;
        while ((exp_qa.size() != 0 || exp_qb.size() != 0) && guard < 8) begin
            tick();
            collect(tag);
            guard++;
        end
        check({tag, "_drain"}, 32'(exp_qa.size() + exp_qb.size()), 32'd0);
        exp_qa.delete();
        exp_qb.delete();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    int n_busy_a, n_busy_b, guard;

    initial begin
        reset = 1'b1;
        read_addr = '0; read_enable = 1'b0;
        write_addr = '0; write_enable = 1'b0; write_byte_en = 1'b0; write_data = '0;
        clear_start = 1'b0;
        w_waddr = '0; w_we = 1'b0; w_be = '0; w_wdata = '0; w_clear = 1'b0;
        for (int i = 0; i < 16; i++) model8[i] = 8'h00;

        // ---- reset state ----
        tick();
        tick();
        check("rst_a_valid", 32'(a_valid), 32'd0);
        check("rst_a_data",  32'(a_rdata), 32'd0);
        check("rst_a_busy",  32'(a_busy),  32'd0);
        check("rst_a_state", 32'(a_state), 32'(IDLE));
        check("rst_b_valid", 32'(b_valid), 32'd0);
        check("rst_b_data",  32'(b_rdata), 32'd0);
        check("rst_w_valid", 32'(w_valid), 32'd0);
        check("rst_w_busy",  32'(w_busy),  32'd0);
        check("rst_w_state", 32'(w_state), 32'(IDLE));
        reset = 1'b0;
        tick();

        // ---- byte-lane writes (16-bit) ----
        write16(4'd5, 16'hABCD, 2'b11);
        write16(4'd5, 16'h1234, 2'b01);
        read_enable = 1'b1; read_addr = 4'd5;
        tick();
        read_enable = 1'b0;
        check("lane_lo_valid", 32'(w_valid), 32'd1);
        check("lane_lo_data",  32'(w_rdata), 32'h0000AB34);
        write16(4'd5, 16'hFFFF, 2'b00);
        read_enable = 1'b1; read_addr = 4'd5;
        tick();
        read_enable = 1'b0;
        check("lane_none", 32'(w_rdata), 32'h0000AB34);
        write16(4'd5, 16'h5678, 2'b10);
        read_enable = 1'b1; read_addr = 4'd5;
        tick();
        read_enable = 1'b0;
        check("lane_hi", 32'(w_rdata), 32'h00005634);
        tick();
        tick();
        tick();

        // ---- same-address collision ----
        write8(4'd7, 8'h00);
        write_enable = 1'b1; write_addr = 4'd7; write_data = 8'h5A; write_byte_en = 1'b1;
        read_enable = 1'b1; read_addr = 4'd7;
        tick();                                     // E1
        model8[7] = 8'h5A;
        write_enable = 1'b0;
        check("coll_a_valid", 32'(a_valid), 32'd1);
        check("coll_a_old",   32'(a_rdata), 32'h00);
        check("coll_b_lat",   32'(b_valid), 32'd0);
        tick();                                     // E2, second read of 7
        read_enable = 1'b0;
        check("coll_a_next",  32'(a_rdata), 32'h5A);
        check("coll_b_valid", 32'(b_valid), 32'd1);
        check("coll_b_new",   32'(b_rdata), 32'h5A);
        tick();                                     // E3
        check("coll_a_idle",  32'(a_valid), 32'd0);
        check("coll_a_hold",  32'(a_rdata), 32'h5A);
        check("coll_b_next",  32'(b_rdata), 32'h5A);
        tick();                                     // E4
        check("coll_b_idle",  32'(b_valid), 32'd0);
        check("coll_b_hold",  32'(b_rdata), 32'h5A);

        // ---- latency, back-to-back reads 0,1,2 ----
        write8(4'd1, 8'h21);
        write8(4'd2, 8'h32);
        write8(4'd0, 8'h10);
        read_enable = 1'b1; read_addr = 4'd0;
        tick();
        check("lat1_a", 32'({a_valid, a_rdata}), 32'h110);
        check("lat1_b", 32'(b_valid), 32'd0);
        read_addr = 4'd1;
        tick();
        check("lat2_a", 32'({a_valid, a_rdata}), 32'h121);
        check("lat2_b", 32'({b_valid, b_rdata}), 32'h110);
        read_addr = 4'd2;
        tick();
        read_enable = 1'b0;
        check("lat3_a", 32'({a_valid, a_rdata}), 32'h132);
        check("lat3_b", 32'({b_valid, b_rdata}), 32'h121);
        tick();
        check("lat4_a", 32'({a_valid, a_rdata}), 32'h032);
        check("lat4_b", 32'({b_valid, b_rdata}), 32'h132);
        tick();
        check("lat5_b", 32'({b_valid, b_rdata}), 32'h032);

        // ---- clear ----
        clear_start = 1'b1;
        write_enable = 1'b1; write_addr = 4'd9; write_data = 8'h44; write_byte_en = 1'b1;
        tick();                                     // E0
        clear_start = 1'b0;
        write_enable = 1'b0;
        check("clr_state", 32'(a_state), 32'(CLEAR));
        n_busy_a = 0; n_busy_b = 0; guard = 0;
        while ((a_busy || b_busy) && guard < 40) begin
            if (a_busy) n_busy_a++;
            if (b_busy) n_busy_b++;
            write_enable = (n_busy_a == 6);        // dropped write mid-clear
            write_addr   = 4'd3;
            write_data   = 8'h11;
            clear_start  = (n_busy_a == 8);        // ignored while clearing
            tick();
            guard++;
        end
        write_enable = 1'b0;
        clear_start  = 1'b0;
        check("clr_busy_a", 32'(n_busy_a), 32'd16);
        check("clr_busy_b", 32'(n_busy_b), 32'd16);
        for (int i = 0; i < 16; i++) model8[i] = 8'hEE;
        write8(4'd4, 8'h66);                        // accepted once busy is low
        read_range(0, 15, "clr_rd");

        // ---- reset mid-clear ----
        for (int i = 0; i < 16; i++) write8(4'(i), 8'h77);
        clear_start = 1'b1;
        read_enable = 1'b1; read_addr = 4'd15;
        tick();                                     // E0
        clear_start = 1'b0;
        check("rmc_busy", 32'(a_busy), 32'd1);
        check("rmc_rd_a", 32'(a_rdata), 32'h77);
        for (int i = 0; i < 6; i++) tick();         // E1..E6 clear addresses 0..5
        check("rmc_rd_b", 32'(b_rdata), 32'h77);
        reset = 1'b1;
        write_enable = 1'b1; write_addr = 4'd10; write_data = 8'h12; write_byte_en = 1'b1;
        tick();                                     // E7
        reset = 1'b0;
        write_enable = 1'b0;
        read_enable = 1'b0;
        check("rmc_a_busy",  32'(a_busy),  32'd0);
        check("rmc_a_valid", 32'(a_valid), 32'd0);
        check("rmc_a_data",  32'(a_rdata), 32'd0);
        check("rmc_a_state", 32'(a_state), 32'(IDLE));
        check("rmc_b_valid", 32'(b_valid), 32'd0);
        check("rmc_b_data",  32'(b_rdata), 32'd0);
        check("rmc_w_valid", 32'(w_valid), 32'd0);
        check("rmc_w_data",  32'(w_rdata), 32'd0);
        tick();
        check("rmc_no_resume", 32'(a_busy), 32'd0);
        for (int i = 0; i < 6; i++) model8[i] = 8'hEE;
        read_range(0, 15, "rmc_rd");

        // ---- reset leaves contents intact (16-bit instance) ----
        read_enable = 1'b1; read_addr = 4'd5;
        tick();
        read_enable = 1'b0;
        check("keep_w_valid", 32'(w_valid), 32'd1);
        check("keep_w_data",  32'(w_rdata), 32'h00005634);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_vram_block
